// File: rtl/cae_aeg_pkg.sv
// Shared types and constants for the AEG register file / launch controller.
package cae_aeg_pkg;

    // Width of one AEG register and of the return data path
    localparam int AEG_DW = 64;

    // Width of the run cycle counter (zero-extended into the AEG)
    localparam int CNT_W = 32;

    // Exception vector width and bit positions
    localparam int EXC_W       = 16;
    localparam int EXC_UNIMPL  = 0;
    localparam int EXC_BAD_IDX = 1;
    localparam int EXC_BUSY    = 2;
    localparam int EXC_TIMEOUT = 3;

    // Launch controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cae_aeg_regfile.sv
// NUM_AEG x 64-bit AEG register file. Three prioritised write sources
// (dispatch > engine status > cycle count) and one registered read port.
// Every register is also exposed on a flattened output bus.
module cae_aeg_regfile
    import cae_aeg_pkg::*;
#(
    parameter int NUM_AEG   = 51,
    parameter int AEG_IDX_W = 6,
    parameter int NUM_ENG   = 8,
    parameter int CYC_IDX   = 2,
    parameter int STS_BASE  = 3
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_wr_en,
    input  logic [AEG_IDX_W-1:0]        i_wr_idx,
    input  logic [AEG_DW-1:0]           i_wr_data,
    input  logic [NUM_ENG-1:0]          i_sts_we,
    input  logic [NUM_ENG*AEG_DW-1:0]   i_sts_data,
    input  logic                        i_cyc_we,
    input  logic [AEG_DW-1:0]           i_cyc_data,
    input  logic                        i_rd_en,
    input  logic [AEG_IDX_W-1:0]        i_rd_idx,
    output logic [AEG_DW-1:0]           o_rd_data,
    output logic                        o_rd_vld,
    output logic [NUM_AEG*AEG_DW-1:0]   o_aeg
);

    logic [AEG_DW-1:0] w_words [NUM_AEG];
    logic [AEG_DW-1:0] r_rd_data;
    logic              r_rd_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AEG; gi++) begin : g_aeg
            logic              w_disp_hit;
            logic              w_sts_hit;
            logic              w_cyc_hit;
            logic [AEG_DW-1:0] w_sts_word;
            logic [AEG_DW-1:0] r_word;

            assign w_disp_hit = i_wr_en && (i_wr_idx == AEG_IDX_W'(gi));
            assign w_cyc_hit  = i_cyc_we && (gi == CYC_IDX);

            // Only registers in the status window have an engine attached
            if (gi >= STS_BASE && gi < STS_BASE + NUM_ENG) begin : g_sts
                assign w_sts_hit  = i_sts_we[gi - STS_BASE];
                assign w_sts_word = i_sts_data[AEG_DW*(gi - STS_BASE) +: AEG_DW];
            end else begin : g_nosts
                assign w_sts_hit  = 1'b0;
                assign w_sts_word = '0;
            end

            // Register update: dispatch beats status beats cycle count
            always_ff @(posedge clk) begin
                if (i_reset) begin
                    r_word <= '0;
                end else if (w_disp_hit) begin
                    r_word <= i_wr_data;
                end else if (w_sts_hit) begin
                    r_word <= w_sts_word;
                end else if (w_cyc_hit) begin
                    r_word <= i_cyc_data;
                end
            end

            assign w_words[gi]                 = r_word;
            assign o_aeg[AEG_DW*gi +: AEG_DW]  = r_word;
        end
    endgenerate

    // Registered read port; returns contents as they were before this cycle's writes
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_words[i_rd_idx];
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_rd_vld  = r_rd_vld;

endmodule

// File: rtl/cae_aeg_ctl.sv
// AEG decode and custom-instruction launch controller for NUM_ENG engines.
// Launches the masked engines on the start CAEP, gathers their done pulses,
// records the run length in AEG[CYC_IDX] and flags decode/run exceptions.
module cae_aeg_ctl
    import cae_aeg_pkg::*;
#(
    parameter int NUM_AEG    = 51,
    parameter int AEG_IDX_W  = 6,
    parameter int NUM_ENG    = 8,
    parameter int CAEP_START = 0,
    parameter int MASK_IDX   = 1,
    parameter int CYC_IDX    = 2,
    parameter int STS_BASE   = 3,
    parameter int TIMEOUT    = 0
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        inst_val,
    input  logic [4:0]                  inst_caep,
    input  logic                        inst_aeg_wr,
    input  logic                        inst_aeg_rd,
    input  logic [17:0]                 inst_aeg_idx,
    input  logic                        err_unimpl,
    input  logic [AEG_DW-1:0]           cae_data,
    input  logic [NUM_ENG-1:0]          eng_done,
    input  logic [NUM_ENG-1:0]          sts_we,
    input  logic [NUM_ENG*AEG_DW-1:0]   sts_data,
    output logic [NUM_ENG-1:0]          eng_start,
    output logic [NUM_AEG*AEG_DW-1:0]   aeg_out,
    output logic [AEG_DW-1:0]           cae_ret_data,
    output logic                        cae_ret_data_vld,
    output logic [EXC_W-1:0]            cae_exception,
    output logic                        cae_idle,
    output logic                        cae_stall
);

    // Last counter value allowed before the watchdog fires
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [NUM_ENG-1:0]   r_mask;
    logic [NUM_ENG-1:0]   r_done_vec;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_ENG-1:0]   r_eng_start;
    logic                 r_stall;
    logic                 r_idle;
    logic                 r_exc_to;
    logic [2:0]           r_exc_lo;

    logic                         w_idx_ok;
    logic                         w_wr_ok;
    logic                         w_rd_ok;
    logic                         w_bad_idx;
    logic                         w_is_start;
    logic [NUM_AEG*AEG_DW-1:0]    w_aeg_flat;
    logic [NUM_ENG-1:0]           w_mask_src;
    logic [NUM_ENG-1:0]           w_done_hit;
    logic                         w_all_done;
    logic                         w_timeout;
    logic                         w_cyc_we;

    // Index check uses all 18 bits so aliases above the table are rejected
    assign w_idx_ok   = inst_aeg_idx < 18'(NUM_AEG);
    assign w_wr_ok    = inst_aeg_wr && w_idx_ok;
    assign w_rd_ok    = inst_aeg_rd && w_idx_ok;
    assign w_bad_idx  = (inst_aeg_wr || inst_aeg_rd) && !w_idx_ok;
    assign w_is_start = inst_val && (inst_caep == 5'(CAEP_START));

    // A mask written in the same cycle as the start takes effect immediately
    assign w_mask_src = (w_wr_ok && inst_aeg_idx == 18'(MASK_IDX))
                      ? cae_data[NUM_ENG-1:0]
                      : w_aeg_flat[AEG_DW*MASK_IDX +: NUM_ENG];

    assign w_done_hit = eng_done & r_mask;
    assign w_all_done = ((r_done_vec | w_done_hit) == r_mask);
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_cyc_we   = (r_state == ST_DONE);

    cae_aeg_regfile #(
        .NUM_AEG   (NUM_AEG),
        .AEG_IDX_W (AEG_IDX_W),
        .NUM_ENG   (NUM_ENG),
        .CYC_IDX   (CYC_IDX),
        .STS_BASE  (STS_BASE)
    ) u_regfile (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_wr_en    (w_wr_ok),
        .i_wr_idx   (inst_aeg_idx[AEG_IDX_W-1:0]),
        .i_wr_data  (cae_data),
        .i_sts_we   (sts_we),
        .i_sts_data (sts_data),
        .i_cyc_we   (w_cyc_we),
        .i_cyc_data ({{(AEG_DW-CNT_W){1'b0}}, r_cnt}),
        .i_rd_en    (w_rd_ok),
        .i_rd_idx   (inst_aeg_idx[AEG_IDX_W-1:0]),
        .o_rd_data  (cae_ret_data),
        .o_rd_vld   (cae_ret_data_vld),
        .o_aeg      (w_aeg_flat)
    );

    // Launch FSM: stall/idle are registered from the next state; the count
    // excludes the RUN cycle in which the run completes or times out
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_done_vec  <= '0;
            r_cnt       <= '0;
            r_eng_start <= '0;
            r_stall     <= 1'b0;
            r_idle      <= 1'b1;
            r_exc_to    <= 1'b0;
        end else begin
            r_eng_start <= '0;
            r_exc_to    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_start) begin
                        r_state     <= ST_LAUNCH;
                        r_mask      <= w_mask_src;
                        r_done_vec  <= '0;
                        r_cnt       <= '0;
                        r_eng_start <= w_mask_src;
                        r_stall     <= 1'b1;
                        r_idle      <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= (r_mask == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    r_done_vec <= r_done_vec | w_done_hit;
                    if (w_all_done) begin
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_state  <= ST_DONE;
                        r_exc_to <= 1'b1;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_stall <= 1'b0;
                    r_idle  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stall <= 1'b0;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    // Decode exceptions, one-cycle pulses registered from the instruction cycle
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_exc_lo <= '0;
        end else begin
            r_exc_lo[EXC_UNIMPL]  <= err_unimpl || (inst_val && !w_is_start);
            r_exc_lo[EXC_BAD_IDX] <= w_bad_idx;
            r_exc_lo[EXC_BUSY]    <= w_is_start && (r_state != ST_IDLE);
        end
    end

    // Assemble the exception vector; unused upper bits stay zero
    always_comb begin
        cae_exception              = '0;
        cae_exception[EXC_UNIMPL]  = r_exc_lo[EXC_UNIMPL];
        cae_exception[EXC_BAD_IDX] = r_exc_lo[EXC_BAD_IDX];
        cae_exception[EXC_BUSY]    = r_exc_lo[EXC_BUSY];
        cae_exception[EXC_TIMEOUT] = r_exc_to;
    end

    assign eng_start = r_eng_start;
    assign aeg_out   = w_aeg_flat;
    assign cae_stall = r_stall;
    assign cae_idle  = r_idle;

endmodule

// File: tb/tb_cae_aeg_ctl.sv
// Bench for cae_aeg_ctl: read data is checked through a scoreboard queue,
// everything else through direct checks against a bench-side AEG model.
module tb_cae_aeg_ctl;

    localparam int NUM_AEG  = 51;
    localparam int NUM_ENG  = 8;
    localparam int MASK_IDX = 1;
    localparam int CYC_IDX  = 2;
    localparam int TIMEOUT  = 10;

    logic                      clk = 1'b0;
    logic                      i_reset = 1'b1;
    logic                      inst_val = 1'b0;
    logic [4:0]                inst_caep = '0;
    logic                      inst_aeg_wr = 1'b0;
    logic                      inst_aeg_rd = 1'b0;
    logic [17:0]               inst_aeg_idx = '0;
    logic                      err_unimpl = 1'b0;
    logic [63:0]               cae_data = '0;
    logic [NUM_ENG-1:0]        eng_done = '0;
    logic [NUM_ENG-1:0]        sts_we = '0;
    logic [NUM_ENG*64-1:0]     sts_data = '0;
    logic [NUM_ENG-1:0]        eng_start;
    logic [NUM_AEG*64-1:0]     aeg_out;
    logic [63:0]               cae_ret_data;
    logic                      cae_ret_data_vld;
    logic [15:0]               cae_exception;
    logic                      cae_idle;
    logic                      cae_stall;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [63:0] sb_q [$];
    logic [63:0] exp_aeg [NUM_AEG];

    always #5 clk = ~clk;

    cae_aeg_ctl #(
        .NUM_AEG(NUM_AEG), .AEG_IDX_W(6), .NUM_ENG(NUM_ENG), .CAEP_START(0),
        .MASK_IDX(MASK_IDX), .CYC_IDX(CYC_IDX), .STS_BASE(3), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .i_reset(i_reset), .inst_val(inst_val), .inst_caep(inst_caep),
        .inst_aeg_wr(inst_aeg_wr), .inst_aeg_rd(inst_aeg_rd), .inst_aeg_idx(inst_aeg_idx),
        .err_unimpl(err_unimpl), .cae_data(cae_data), .eng_done(eng_done),
        .sts_we(sts_we), .sts_data(sts_data), .eng_start(eng_start), .aeg_out(aeg_out),
        .cae_ret_data(cae_ret_data), .cae_ret_data_vld(cae_ret_data_vld),
        .cae_exception(cae_exception), .cae_idle(cae_idle), .cae_stall(cae_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_aeg(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < NUM_AEG; i++)
            if (aeg_out[64*i +: 64] !== exp_aeg[i]) nbad++;
        check(tag, 64'(nbad), 64'd0);
    endtask

    task automatic aeg_wr(input int idx, input logic [63:0] d);
        inst_aeg_wr  = 1'b1;
        inst_aeg_idx = 18'(idx);
        cae_data     = d;
        step();
        inst_aeg_wr = 1'b0;
        if (idx < NUM_AEG) exp_aeg[idx] = d;
        $display("wr   idx=%0d data=0x%0h exc=0x%0h", idx, d, cae_exception);
    endtask

    task automatic aeg_rd(input int idx);
        inst_aeg_rd  = 1'b1;
        inst_aeg_idx = 18'(idx);
        sb_q.push_back(exp_aeg[idx]);
        step();
        inst_aeg_rd = 1'b0;
        check("rd_vld_latency", 64'(cae_ret_data_vld), 64'd1);
        $display("rd   idx=%0d data=0x%0h", idx, cae_ret_data);
    endtask

    // Start a run, apply up to three timed done vectors (k = cycles after LAUNCH)
    task automatic run(input logic [NUM_ENG-1:0] mask, input logic bypass,
                       input int ta, input logic [NUM_ENG-1:0] va,
                       input int tb, input logic [NUM_ENG-1:0] vb,
                       input int tc, input logic [NUM_ENG-1:0] vc,
                       input int exp_stall, input logic [63:0] exp_cnt, input int exp_to);
        int k, n, n_to, n_extra;
        inst_val  = 1'b1;
        inst_caep = 5'd0;
        if (bypass) begin
            inst_aeg_wr  = 1'b1;
            inst_aeg_idx = 18'(MASK_IDX);
            cae_data     = 64'(mask);
            exp_aeg[MASK_IDX] = 64'(mask);
        end
        step();
        inst_val    = 1'b0;
        inst_aeg_wr = 1'b0;
        check("launch_start", 64'(eng_start), 64'(mask));
        check("launch_stall", 64'(cae_stall), 64'd1);
        k = 0; n = 1; n_to = 0; n_extra = 0;
        while (k < 60) begin
            step();
            k++;
            if (cae_exception[3]) n_to++;
            if (eng_start != '0) n_extra++;
            if (!cae_stall) break;
            n++;
            eng_done = (k == ta ? va : '0) | (k == tb ? vb : '0) | (k == tc ? vc : '0);
        end
        eng_done = '0;
        check("stall_cycles", 64'(n), 64'(exp_stall));
        check("timeout_pulses", 64'(n_to), 64'(exp_to));
        check("extra_start", 64'(n_extra), 64'd0);
        check("idle_after", 64'(cae_idle), 64'd1);
        exp_aeg[CYC_IDX] = exp_cnt;
        check("cyc_aeg", aeg_out[64*CYC_IDX +: 64], exp_cnt);
        $display("run  mask=0x%0h stall=%0d count=%0d timeouts=%0d", mask, n,
                 aeg_out[64*CYC_IDX +: 64], n_to);
    endtask

    // Scoreboard consumer for the read-return port
    always @(negedge clk) begin
        if (i_reset === 1'b0 && cae_ret_data_vld === 1'b1) begin
            if (sb_q.size() == 0) check("ret_unexpected", 64'd1, 64'd0);
            else check("ret_data", cae_ret_data, sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NUM_AEG; i++) exp_aeg[i] = '0;
        repeat (3) step();
        check("rst_idle", 64'(cae_idle), 64'd1);
        check("rst_stall", 64'(cae_stall), 64'd0);
        check("rst_start", 64'(eng_start), 64'd0);
        check("rst_exc", 64'(cae_exception), 64'd0);
        check("rst_vld", 64'(cae_ret_data_vld), 64'd0);
        check_aeg("rst_aeg");
        i_reset = 1'b0;
        step();

        // Basic write/read, including the top valid index
        aeg_wr(5, 64'hDEADBEEF);
        aeg_rd(5);
        step();
        check("rd_vld_pulse", 64'(cae_ret_data_vld), 64'd0);
        aeg_rd(50);
        aeg_wr(50, 64'h0123_4567_89AB_CDEF);
        aeg_rd(50);

        // Out-of-range read
        inst_aeg_rd = 1'b1; inst_aeg_idx = 18'd51;
        step();
        inst_aeg_rd = 1'b0;
        check("badrd_exc", 64'(cae_exception), 64'h2);
        check("badrd_novld", 64'(cae_ret_data_vld), 64'd0);
        $display("rd   idx=51 exc=0x%0h", cae_exception);
        step();
        check("badrd_exc_clr", 64'(cae_exception), 64'd0);

        // Out-of-range write whose low bits alias AEG 5
        aeg_wr(32'h10005, 64'hBAD);
        check("badwr_exc", 64'(cae_exception), 64'h2);
        check_aeg("badwr_nochange");

        // Unimplemented: non-start CAEP, then decoder flag
        inst_val = 1'b1; inst_caep = 5'd3;
        step();
        inst_val = 1'b0;
        check("caep_unimpl", 64'(cae_exception), 64'h1);
        $display("inst caep=3 exc=0x%0h", cae_exception);
        err_unimpl = 1'b1;
        step();
        err_unimpl = 1'b0;
        check("err_unimpl", 64'(cae_exception), 64'h1);
        $display("inst err_unimpl exc=0x%0h", cae_exception);

        // Mask 0x05: unmasked done at +2 ignored, eng0 at +3, eng2 at +7
        aeg_wr(MASK_IDX, 64'h05);
        run(8'h05, 1'b0, 2, 8'h02, 3, 8'h01, 7, 8'h04, 9, 64'd6, 0);
        aeg_rd(CYC_IDX);

        // Mask 0 written in the start cycle itself
        run(8'h00, 1'b1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 2, 64'd0, 0);
        check_aeg("mask0_model");

        // Watchdog
        aeg_wr(MASK_IDX, 64'h01);
        run(8'h01, 1'b0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 12, 64'd9, 1);
        aeg_rd(CYC_IDX);

        // Busy start plus dispatch/status collision on AEG 6
        inst_val = 1'b1; inst_caep = 5'd0;
        step();
        inst_val = 1'b0;
        check("mr_launch", 64'(eng_start), 64'h1);
        step();
        step();
        inst_val = 1'b1; inst_caep = 5'd0;
        inst_aeg_wr = 1'b1; inst_aeg_idx = 18'd6; cae_data = 64'hA5A5_0000_0000_5A5A;
        sts_we = 8'h08; sts_data[3*64 +: 64] = 64'h1234;
        step();
        inst_val = 1'b0; inst_aeg_wr = 1'b0; sts_we = '0;
        exp_aeg[6] = 64'hA5A5_0000_0000_5A5A;
        check("busy_exc", 64'(cae_exception), 64'h4);
        check("busy_stall", 64'(cae_stall), 64'd1);
        check("prio_dispatch", aeg_out[6*64 +: 64], exp_aeg[6]);
        $display("busy start + collide aeg6=0x%0h exc=0x%0h", aeg_out[6*64 +: 64], cae_exception);
        sts_we = 8'h08;
        step();
        sts_we = '0;
        exp_aeg[6] = 64'h1234;
        check("sts_in_run", aeg_out[6*64 +: 64], exp_aeg[6]);
        check("busy_exc_clr", 64'(cae_exception), 64'd0);
        aeg_rd(6);
        step();
        check("still_run", 64'(cae_stall), 64'd1);

        // Reset in RUN
        i_reset = 1'b1;
        step();
        for (int i = 0; i < NUM_AEG; i++) exp_aeg[i] = '0;
        check("mrst_idle", 64'(cae_idle), 64'd1);
        check("mrst_stall", 64'(cae_stall), 64'd0);
        check("mrst_start", 64'(eng_start), 64'd0);
        check_aeg("mrst_aeg");
        $display("reset in run idle=%0d", cae_idle);
        i_reset = 1'b0;
        begin
            int s;
            s = 0;
            repeat (12) begin
                step();
                if (cae_stall) s++;
            end
            check("mrst_no_resume", 64'(s), 64'd0);
        end
        check("mrst_cyc", aeg_out[64*CYC_IDX +: 64], 64'd0);
        aeg_rd(CYC_IDX);
        step();
        step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cae_aeg_ctl.md
Name: cae_aeg_ctl

Overview:
Parametrised AEG register file and custom-instruction launch controller for a personality with NUM_ENG independent engines. It decodes AEG reads and writes, launches the engines selected by a mask AEG on the start CAEP, and collects per-engine done and status writeback. It drives cae_idle, cae_stall, cae_ret_data and the exception bits, and reports a per-run cycle count and watchdog timeout. It sits between instdec and the engine array (e.g. bps_master/bps instances) inside cae_pers.

Parameters:
NUM_AEG, 51, number of 64-bit AEG registers
AEG_IDX_W, 6, index bits used for register select (2^AEG_IDX_W >= NUM_AEG)
NUM_ENG, 8, number of engines (1..32)
CAEP_START, 0, CAEP code that launches a run
MASK_IDX, 1, AEG holding engine enable mask in bits [NUM_ENG-1:0]
CYC_IDX, 2, AEG receiving the run cycle count
STS_BASE, 3, AEG[STS_BASE+e] receives engine e status (STS_BASE+NUM_ENG <= NUM_AEG)
TIMEOUT, 0, watchdog limit in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock
i_reset  in  1  synchronous active-high reset
inst_val  in  1  decoded custom instruction valid
inst_caep  in  5  CAEP code
inst_aeg_wr  in  1  AEG write strobe
inst_aeg_rd  in  1  AEG read strobe
inst_aeg_idx  in  18  AEG index
err_unimpl  in  1  decoder unimplemented-instruction flag
cae_data  in  64  AEG write data
eng_done  in  NUM_ENG  per-engine done pulse
sts_we  in  NUM_ENG  per-engine status write strobe
sts_data  in  NUM_ENG*64  per-engine status words, engine e at [64e+63:64e]
eng_start  out  NUM_ENG  one-cycle start pulse per engine
aeg_out  out  NUM_AEG*64  flattened AEG contents
cae_ret_data  out  64  read data
cae_ret_data_vld  out  1  read data valid
cae_exception  out  16  [0] unimpl, [1] bad AEG index, [2] start while busy, [3] timeout, [15:4] zero
cae_idle  out  1  high when no run is active
cae_stall  out  1  high while a run is active

Behaviour:
- Reset: all AEGs, eng_start, ret_data, ret_vld and exceptions are 0; cae_idle=1; cae_stall=0; FSM=IDLE; done-collect and counter cleared. Reset mid-run aborts immediately with no CYC_IDX write.
- Index valid iff inst_aeg_idx < NUM_AEG, compared on the full 18 bits.
- Valid read: ret_vld=1 and ret_data=AEG[idx] exactly 1 cycle later.
- Invalid read or write: exception[1]=1 for 1 cycle, one cycle later; no ret_vld; no state change.
- Exceptions are single-cycle registered pulses.
- exception[0] is set one cycle after err_unimpl, or one cycle after inst_val with caep != CAEP_START.
- AEG write priority, same cycle and same index: dispatch write, then engine status, then cycle-count write. The losing write is dropped.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE -> LAUNCH on inst_val && caep==CAEP_START.
  - Latch mask = AEG[MASK_IDX][NUM_ENG-1:0], or cae_data if the same cycle writes MASK_IDX.
  - Clear the counter and the done vector.
- LAUNCH:
  - eng_start = mask for exactly 1 cycle.
  - If mask==0, go to DONE; otherwise go to RUN.
- RUN:
  - done_vec |= eng_done & mask; done on unmasked engines is ignored.
  - Counter increments each cycle and saturates at all-ones.
  - Go to DONE when (done_vec | (eng_done & mask)) == mask, so a same-cycle done counts.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: exception[3] pulse, go to DONE.
- DONE:
  - AEG[CYC_IDX] = counter (LAUNCH to DONE, exclusive of DONE).
  - Go to IDLE.
- cae_stall = (state != IDLE); cae_idle = !cae_stall. Both are registered from the next-state, so stall is high the cycle after the start instruction.
- Start while not IDLE: ignored, exception[2] pulse. AEG reads and writes during a run are serviced normally.
- sts_we[e] writes AEG[STS_BASE+e] in any state.
- eng_done outside RUN is ignored.

Decomposition:
- Package cae_aeg_pkg: FSM state enum, exception bit position constants, AEG data width constant 64.
- One natural sub-module, cae_aeg_regfile: NUM_AEG x 64 registers with the three prioritised write ports and a registered read port.
- FSM, counter and exception logic stay in cae_aeg_ctl.

Test Plan:
- Write 0xDEADBEEF to AEG 5, read AEG 5 -> ret_vld 1 cycle after the read, data 0xDEADBEEF; read idx 51 -> exception[1] pulse, no ret_vld.
- MASK=0x05, start, engine0 done at cycle +3 and engine2 done at +7 after LAUNCH -> eng_start=0x05 for one cycle, stall high until DONE, AEG[2]=count matching the done timing.
- MASK=0, start -> eng_start stays 0, run completes with AEG[2]=0, stall high exactly 2 cycles.
- TIMEOUT=10, MASK=0x01, no done -> exception[3] pulse, DONE, AEG[2]=9.
- Start during RUN -> exception[2]; sts_we[3] with 0x1234 during the same cycle as a dispatch write to AEG 6 -> AEG[6]=dispatch data, AEG[6] status write dropped.
- i_reset asserted in RUN -> next cycle idle=1, eng_start=0, AEG[2] unchanged at 0, all AEGs 0.
